// File: rtl/keyadd_round_sequencer.sv
// Round controller for the 16-bit key-addition datapath, with time-redundant round evaluation.
// Latency: 2*ROUNDS cycles from input accept to io_out_valid (2 cycles to a fault abort on the first round).
// Backpressure: single operation in flight; io_in_ready is low while busy and the result is held until io_out_ready.
module keyadd_round_sequencer #(
  parameter int ROUNDS = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_in_valid,
  output logic        io_in_ready,
  input  logic [15:0] io_in_state,
  input  logic [15:0] io_in_key,
  output logic [15:0] io_ka_state,
  output logic [15:0] io_ka_key,
  input  logic [15:0] io_ka_out,
  output logic        io_out_valid,
  input  logic        io_out_ready,
  output logic [15:0] io_out_data,
  output logic        io_fault,
  output logic [7:0]  io_fault_count
);

  // Index of the last round; the round counter never needs to go past it.
  localparam logic [7:0] LAST_R = 8'(ROUNDS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COMPUTE = 3'd1,
    CHECK   = 3'd2,
    DONE    = 3'd3,
    FAULT   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] st_q, st_d;
  logic [15:0] k_q, k_d;
  logic [15:0] first_q, first_d;
  logic [15:0] result_q, result_d;
  logic [7:0]  r_q, r_d;
  logic [7:0]  fault_count_q, fault_count_d;

  // Rotations used by the key schedule between rounds.
  function automatic logic [15:0] rotl3(input logic [15:0] x);
    return {x[12:0], x[15:13]};
  endfunction

  function automatic logic [15:0] rotl5(input logic [15:0] x);
    return {x[10:0], x[15:11]};
  endfunction

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      st_q          <= 16'h0000;
      k_q           <= 16'h0000;
      first_q       <= 16'h0000;
      result_q      <= 16'h0000;
      r_q           <= 8'h00;
      fault_count_q <= 8'h00;
    end else begin
      state_q       <= state_d;
      st_q          <= st_d;
      k_q           <= k_d;
      first_q       <= first_d;
      result_q      <= result_d;
      r_q           <= r_d;
      fault_count_q <= fault_count_d;
    end
  end

  // Next-state and register updates: each round is evaluated in COMPUTE, re-evaluated and compared in CHECK.
  always_comb begin
    state_d       = state_q;
    st_d          = st_q;
    k_d           = k_q;
    first_d       = first_q;
    result_d      = result_q;
    r_d           = r_q;
    fault_count_d = fault_count_q;

    unique case (state_q)
      IDLE: begin
        if (io_in_valid) begin
          st_d    = io_in_state;
          k_d     = io_in_key;
          r_d     = 8'h00;
          state_d = COMPUTE;
        end
      end

      COMPUTE: begin
        first_d = io_ka_out;
        state_d = CHECK;
      end

      CHECK: begin
        if (io_ka_out != first_q) begin
          // Redundant evaluations disagree: drop the result and count the abort.
          result_d      = 16'h0000;
          fault_count_d = (fault_count_q == 8'hFF) ? 8'hFF : fault_count_q + 8'd1;
          state_d       = FAULT;
        end else if (r_q == LAST_R) begin
          // Final round output leaves unrotated.
          result_d = io_ka_out;
          state_d  = DONE;
        end else begin
          st_d    = rotl3(io_ka_out);
          k_d     = rotl5(k_q) ^ {8'h00, r_q + 8'd1};
          r_d     = r_q + 8'd1;
          state_d = COMPUTE;
        end
      end

      DONE: begin
        if (io_out_ready) begin
          state_d = IDLE;
        end
      end

      FAULT: begin
        if (io_out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode from state and registers only, so io_ka_out never reaches an output combinationally.
  always_comb begin
    io_in_ready    = 1'b0;
    io_out_valid   = 1'b0;
    io_out_data    = 16'h0000;
    io_fault       = 1'b0;
    io_ka_state    = st_q;
    io_ka_key      = k_q;
    io_fault_count = fault_count_q;

    unique case (state_q)
      IDLE: begin
        io_in_ready = 1'b1;
      end
      DONE: begin
        io_out_valid = 1'b1;
        io_out_data  = result_q;
      end
      FAULT: begin
        io_out_valid = 1'b1;
        io_fault     = 1'b1;
      end
      default: begin
        io_in_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_keyadd_round_sequencer.sv
// Bench for keyadd_round_sequencer: two instances (ROUNDS=1 and ROUNDS=2), each closed
// around a behavioural key-addition datapath with a bit-0 fault-injection hook.
module tb_keyadd_round_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // Shared stimulus
  logic        sel = 1'b0;   // 0: ROUNDS=1 instance, 1: ROUNDS=2 instance
  logic        flip = 1'b0;
  logic        v1 = 1'b0, v2 = 1'b0;
  logic [15:0] in_state = 16'h0000, in_key = 16'h0000;
  logic        out_ready = 1'b1;

  // Instance 1 signals
  logic        in_ready1, out_valid1, fault1;
  logic [15:0] ka_state1, ka_key1, ka_out1, out_data1;
  logic [7:0]  fault_count1;
  // Instance 2 signals
  logic        in_ready2, out_valid2, fault2;
  logic [15:0] ka_state2, ka_key2, ka_out2, out_data2;
  logic [7:0]  fault_count2;

  // Key-addition datapath models with injectable bit-0 flip
  assign ka_out1 = ka_state1 ^ ka_key1 ^ {15'h0000, flip & ~sel};
  assign ka_out2 = ka_state2 ^ ka_key2 ^ {15'h0000, flip & sel};

  keyadd_round_sequencer #(.ROUNDS(1)) u_r1 (
    .clock(clock), .reset(reset),
    .io_in_valid(v1), .io_in_ready(in_ready1),
    .io_in_state(in_state), .io_in_key(in_key),
    .io_ka_state(ka_state1), .io_ka_key(ka_key1), .io_ka_out(ka_out1),
    .io_out_valid(out_valid1), .io_out_ready(out_ready),
    .io_out_data(out_data1), .io_fault(fault1), .io_fault_count(fault_count1)
  );

  keyadd_round_sequencer #(.ROUNDS(2)) u_r2 (
    .clock(clock), .reset(reset),
    .io_in_valid(v2), .io_in_ready(in_ready2),
    .io_in_state(in_state), .io_in_key(in_key),
    .io_ka_state(ka_state2), .io_ka_key(ka_key2), .io_ka_out(ka_out2),
    .io_out_valid(out_valid2), .io_out_ready(out_ready),
    .io_out_data(out_data2), .io_fault(fault2), .io_fault_count(fault_count2)
  );

  // Observed view of the selected instance
  logic        o_in_ready, o_valid, o_fault;
  logic [15:0] o_data, o_ka_state, o_ka_key;
  logic [7:0]  o_count;
  assign o_in_ready = sel ? in_ready2    : in_ready1;
  assign o_valid    = sel ? out_valid2   : out_valid1;
  assign o_fault    = sel ? fault2       : fault1;
  assign o_data     = sel ? out_data2    : out_data1;
  assign o_ka_state = sel ? ka_state2    : ka_state1;
  assign o_ka_key   = sel ? ka_key2      : ka_key1;
  assign o_count    = sel ? fault_count2 : fault_count1;

  typedef struct {
    logic [15:0] data;
    logic        fault;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad = 0;
  int fc_exp1 = 0;
  int fc_exp2 = 0;
  logic [15:0] last_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [15:0] s, input logic [15:0] k, input int rounds);
    logic [15:0] st, kk, o;
    st = s;
    kk = k;
    o  = 16'h0000;
    for (int r = 0; r < rounds; r++) begin
      o = st ^ kk;
      if (r < rounds - 1) begin
        st = {o[12:0], o[15:13]};
        kk = {kk[10:0], kk[15:11]} ^ {8'h00, 8'(r + 1)};
      end
    end
    return o;
  endfunction

  // One operation; starts and ends just after a falling edge.
  // flip_at >= 0 flips io_ka_out bit 0 in the cycle seen at that cycle count (1 = first CHECK).
  task automatic run_op(input logic which, input logic [15:0] s, input logic [15:0] k,
                        input int rounds, input int flip_at, input int hold);
    exp_t e;
    exp_t got;
    int cnt;
    sel = which;
    in_state = s;
    in_key = k;
    out_ready = (hold == 0);
    if (flip_at >= 0) begin
      e.data = 16'h0000; e.fault = 1'b1; e.lat = flip_at + 1;
    end else begin
      e.data = model(s, k, rounds); e.fault = 1'b0; e.lat = 2 * rounds;
    end
    sb.push_back(e);
    #1;
    check("in_ready_idle", {31'd0, o_in_ready}, 32'd1);
    if (which) v2 = 1'b1; else v1 = 1'b1;
    @(posedge clock); @(negedge clock);
    v1 = 1'b0; v2 = 1'b0;
    cnt = 0;
    check("in_ready_busy", {31'd0, o_in_ready}, 32'd0);
    while (!o_valid && cnt < 64) begin
      flip = (cnt == flip_at);
      @(posedge clock); @(negedge clock);
      cnt++;
    end
    flip = 1'b0;
    got = sb.pop_front();
    check("latency", cnt, got.lat);
    check("out_data", {16'd0, o_data}, {16'd0, got.data});
    check("out_fault", {31'd0, o_fault}, {31'd0, got.fault});
    if (got.fault) begin
      if (which) fc_exp2 = (fc_exp2 < 255) ? fc_exp2 + 1 : 255;
      else       fc_exp1 = (fc_exp1 < 255) ? fc_exp1 + 1 : 255;
    end
    check("fault_count", {24'd0, o_count}, which ? fc_exp2 : fc_exp1);
    last_data = o_data;
    for (int i = 0; i < hold; i++) begin
      @(posedge clock); @(negedge clock);
      check("hold_valid", {31'd0, o_valid}, 32'd1);
      check("hold_data", {16'd0, o_data}, {16'd0, last_data});
      check("hold_in_ready", {31'd0, o_in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clock); @(negedge clock);
    check("post_in_ready", {31'd0, o_in_ready}, 32'd1);
    check("post_valid", {31'd0, o_valid}, 32'd0);
  endtask

  initial begin
    int cnt;
    logic [15:0] rs, rk;

    // Reset state for both instances
    #1;
    for (int w = 0; w < 2; w++) begin
      sel = w[0];
      #1;
      check("rst_in_ready", {31'd0, o_in_ready}, 32'd1);
      check("rst_valid", {31'd0, o_valid}, 32'd0);
      check("rst_data", {16'd0, o_data}, 32'd0);
      check("rst_fault", {31'd0, o_fault}, 32'd0);
      check("rst_count", {24'd0, o_count}, 32'd0);
      check("rst_ka_state", {16'd0, o_ka_state}, 32'd0);
      check("rst_ka_key", {16'd0, o_ka_key}, 32'd0);
    end
    @(negedge clock); @(negedge clock);
    reset = 1'b0;

    // Directed vectors from the reference values
    run_op(1'b0, 16'h1234, 16'h00FF, 1, -1, 0);
    check("vec_r1", {16'd0, last_data}, 32'h12CB);
    run_op(1'b1, 16'h1234, 16'h00FF, 2, -1, 0);
    check("vec_r2", {16'd0, last_data}, 32'h89B9);

    // Fault on first CHECK
    run_op(1'b1, 16'h1234, 16'h00FF, 2, 1, 0);
    check("fault_cnt_one", {24'd0, fault_count2}, 32'd1);

    // Output backpressure, then back-to-back accept
    run_op(1'b1, 16'hA5C3, 16'h3C5A, 2, -1, 10);
    run_op(1'b1, 16'h0F0F, 16'hFFFF, 2, -1, 0);
    run_op(1'b0, 16'hBEEF, 16'hCAFE, 1, -1, 3);

    // Reset during the second COMPUTE
    sel = 1'b1;
    in_state = 16'h1234; in_key = 16'h00FF;
    v2 = 1'b1;
    @(posedge clock); @(negedge clock);
    v2 = 1'b0;
    cnt = 0;
    while (cnt < 2) begin
      @(posedge clock); @(negedge clock);
      cnt++;
    end
    check("pre_rst_ka_state", {16'd0, o_ka_state}, 32'h9658);
    check("pre_rst_ka_key", {16'd0, o_ka_key}, 32'h1FE1);
    reset = 1'b1;
    #1;
    fc_exp1 = 0; fc_exp2 = 0;
    check("mid_rst_in_ready", {31'd0, o_in_ready}, 32'd1);
    check("mid_rst_valid", {31'd0, o_valid}, 32'd0);
    check("mid_rst_count", {24'd0, o_count}, 32'd0);
    check("mid_rst_ka_state", {16'd0, o_ka_state}, 32'd0);
    @(posedge clock); @(negedge clock);
    reset = 1'b0;
    @(posedge clock); @(negedge clock);
    check("after_rst_in_ready", {31'd0, o_in_ready}, 32'd1);
    check("after_rst_valid", {31'd0, o_valid}, 32'd0);
    check("after_rst_data", {16'd0, o_data}, 32'd0);
    check("after_rst_fault", {31'd0, o_fault}, 32'd0);
    run_op(1'b1, 16'h1234, 16'h00FF, 2, -1, 0);

    // Random operations against the model
    for (int i = 0; i < 6; i++) begin
      rs = 16'($urandom);
      rk = 16'($urandom);
      run_op(1'b1, rs, rk, 2, -1, 0);
      run_op(1'b0, rs, rk, 1, -1, 0);
    end

    // Fault counter saturation
    for (int i = 0; i < 256; i++) begin
      run_op(1'b1, 16'(i), 16'h5555, 2, 1, 0);
    end
    check("fault_count_sat", {24'd0, fault_count2}, 32'hFF);
    run_op(1'b1, 16'h1234, 16'h00FF, 2, -1, 0);
    check("sat_then_good", {16'd0, last_data}, 32'h89B9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
